// File: rtl/dist_ram_pkg.sv
// Shared types and defaults for the two-port distributed RAM arbiter.
package dist_ram_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_id_t;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } lock_state_t;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_ADDR_WIDTH = 4;
  localparam int DEFAULT_MAX_BURST  = 4;

  function automatic port_id_t other_port(input port_id_t p);
    return (p == PORT_A) ? PORT_B : PORT_A;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter2.sv
// Two-port round-robin arbiter with bounded locked bursts.
// Grant is combinational; last grant, lock owner and burst count are registered.
module rr_lock_arbiter2
  import dist_ram_pkg::*;
#(
  parameter int MAX_BURST = DEFAULT_MAX_BURST
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     a_valid_i,
  input  logic     a_lock_i,
  input  logic     b_valid_i,
  input  logic     b_lock_i,
  output logic     grant_vld_o,
  output port_id_t grant_id_o
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  lock_state_t      state_q, state_d;
  port_id_t         last_q, last_d;
  port_id_t         owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic owner_valid, owner_lock, hold, grant_lock;

  always_comb begin
    owner_valid = (owner_q == PORT_A) ? a_valid_i : b_valid_i;
    owner_lock  = (owner_q == PORT_A) ? a_lock_i  : b_lock_i;
    hold        = (state_q == LOCKED) && owner_valid && owner_lock &&
                  (cnt_q < CNT_W'(MAX_BURST));
  end

  // Outputs are forced idle while reset is held.
  always_comb begin
    grant_vld_o = 1'b0;
    grant_id_o  = PORT_A;
    if (rst_n) begin
      if (hold) begin
        grant_vld_o = 1'b1;
        grant_id_o  = owner_q;
      end else if (a_valid_i && b_valid_i) begin
        grant_vld_o = 1'b1;
        grant_id_o  = other_port(last_q);
      end else if (a_valid_i) begin
        grant_vld_o = 1'b1;
        grant_id_o  = PORT_A;
      end else if (b_valid_i) begin
        grant_vld_o = 1'b1;
        grant_id_o  = PORT_B;
      end
    end
    grant_lock = (grant_id_o == PORT_A) ? a_lock_i : b_lock_i;
  end

  // A normally-arbitrated cycle leaves the lock; it re-enters for whoever won with lock set.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (grant_vld_o) last_d = grant_id_o;
    if (hold) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (grant_vld_o && grant_lock) begin
      state_d = LOCKED;
      owner_d = grant_id_o;
      cnt_d   = CNT_W'(1);
    end else begin
      state_d = UNLOCKED;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNLOCKED;
      last_q  <= PORT_B;
      owner_q <= PORT_A;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/dist_ram_arbiter.sv
// Shares one single-port synchronous RAM between two clients; one response
// per accepted request, returned exactly one cycle after acceptance.
module dist_ram_arbiter
  import dist_ram_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  input  logic                  a_req_lock,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  input  logic                  b_req_lock,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
);

  logic     grant_vld;
  port_id_t grant_id;
  logic     pend_vld_q;
  port_id_t pend_id_q;

  rr_lock_arbiter2 #(
    .MAX_BURST(MAX_BURST)
  ) u_arb (
    .clk        (clk),
    .rst_n      (rst_n),
    .a_valid_i  (a_req_valid),
    .a_lock_i   (a_req_lock),
    .b_valid_i  (b_req_valid),
    .b_lock_i   (b_req_lock),
    .grant_vld_o(grant_vld),
    .grant_id_o (grant_id)
  );

  always_comb begin
    a_req_ready = grant_vld && (grant_id == PORT_A);
    b_req_ready = grant_vld && (grant_id == PORT_B);
    ram_en      = grant_vld;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_din     = '0;
    if (a_req_ready) begin
      ram_we   = a_req_we;
      ram_addr = a_req_addr;
      ram_din  = a_req_wdata;
    end else if (b_req_ready) begin
      ram_we   = b_req_we;
      ram_addr = b_req_addr;
      ram_din  = b_req_wdata;
    end
  end

  // RAM read data lands one cycle after enable, so the tracker is one stage deep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld_q <= 1'b0;
      pend_id_q  <= PORT_A;
    end else begin
      pend_vld_q <= grant_vld;
      if (grant_vld) pend_id_q <= grant_id;
    end
  end

  always_comb begin
    a_rsp_valid = pend_vld_q && (pend_id_q == PORT_A);
    b_rsp_valid = pend_vld_q && (pend_id_q == PORT_B);
    a_rsp_rdata = a_rsp_valid ? ram_dout : '0;
    b_rsp_rdata = b_rsp_valid ? ram_dout : '0;
  end

endmodule

// File: tb/tb_dist_ram_arbiter.sv
// Directed bench for dist_ram_arbiter with a behavioural arbitration/RAM model
// checked every cycle, plus hand-computed literal expectations per scenario.
module tb_dist_ram_arbiter;
  import dist_ram_pkg::*;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          a_req_valid, a_req_ready, a_req_we, a_req_lock, a_rsp_valid;
  logic [AW-1:0] a_req_addr;
  logic [DW-1:0] a_req_wdata, a_rsp_rdata;
  logic          b_req_valid, b_req_ready, b_req_we, b_req_lock, b_rsp_valid;
  logic [AW-1:0] b_req_addr;
  logic [DW-1:0] b_req_wdata, b_rsp_rdata;
  logic          ram_en, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_dout;

  always #5 clk = ~clk;

  dist_ram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
    .a_req_addr(a_req_addr), .a_req_wdata(a_req_wdata), .a_req_lock(a_req_lock),
    .a_rsp_valid(a_rsp_valid), .a_rsp_rdata(a_rsp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
    .b_req_addr(b_req_addr), .b_req_wdata(b_req_wdata), .b_req_lock(b_req_lock),
    .b_rsp_valid(b_rsp_valid), .b_rsp_rdata(b_rsp_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  // Synchronous single-port RAM, read-before-write, not cleared by arbiter reset.
  logic [DW-1:0] ram_mem [16];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_dout <= ram_mem[ram_addr];
      if (ram_we) ram_mem[ram_addr] <= ram_din;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Model state: last winner, lock owner (-1 = none) with its streak length,
  // the one outstanding response, and a shadow of RAM contents.
  int            m_last, m_owner, m_streak, m_pend_port;
  bit            m_pend_vld;
  logic [DW-1:0] m_pend_data;
  logic [DW-1:0] m_mem [16];
  int            glog[$];

  initial begin
    bit            v[2], l[2], w[2], hold;
    logic [AW-1:0] ad[2];
    logic [DW-1:0] wd[2];
    logic [13:0]   exp_bus;
    logic [8:0]    exp_a, exp_b;
    int            eg;
    m_last = 1; m_owner = -1; m_streak = 0; m_pend_vld = 0; m_pend_port = 0; m_pend_data = '0;
    for (int i = 0; i < 16; i++) m_mem[i] = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_ctrl", {a_req_ready, b_req_ready, a_rsp_valid, b_rsp_valid, ram_en, ram_we}, 0);
        chk("rst_data", {ram_addr, ram_din, a_rsp_rdata, b_rsp_rdata}, 0);
        m_last = 1; m_owner = -1; m_streak = 0; m_pend_vld = 0;
      end else begin
        v[0] = a_req_valid; l[0] = a_req_lock; w[0] = a_req_we; ad[0] = a_req_addr; wd[0] = a_req_wdata;
        v[1] = b_req_valid; l[1] = b_req_lock; w[1] = b_req_we; ad[1] = b_req_addr; wd[1] = b_req_wdata;
        hold = 0;
        if (m_owner >= 0) hold = v[m_owner] && l[m_owner] && (m_streak < MB);
        if (hold)               eg = m_owner;
        else if (v[0] && v[1])  eg = 1 - m_last;
        else if (v[0])          eg = 0;
        else if (v[1])          eg = 1;
        else                    eg = -1;
        exp_bus = (eg < 0) ? 14'd0 : {1'b1, w[eg], ad[eg], wd[eg]};
        exp_a = (m_pend_vld && m_pend_port == 0) ? {1'b1, m_pend_data} : 9'd0;
        exp_b = (m_pend_vld && m_pend_port == 1) ? {1'b1, m_pend_data} : 9'd0;
        chk("a_req_ready", a_req_ready, (eg == 0) ? 1 : 0);
        chk("b_req_ready", b_req_ready, (eg == 1) ? 1 : 0);
        chk("ram_bus", {ram_en, ram_we, ram_addr, ram_din}, exp_bus);
        chk("a_rsp", {a_rsp_valid, a_rsp_rdata}, exp_a);
        chk("b_rsp", {b_rsp_valid, b_rsp_rdata}, exp_b);
        chk("lock_state", dut.u_arb.state_q, (m_owner >= 0) ? LOCKED : UNLOCKED);
        m_pend_vld = (eg >= 0);
        if (eg >= 0) begin
          m_pend_port = eg;
          m_pend_data = m_mem[ad[eg]];
          if (w[eg]) m_mem[ad[eg]] = wd[eg];
          m_last = eg;
          glog.push_back(eg);
        end
        if (hold) m_streak++;
        else if (eg >= 0 && l[eg]) begin m_owner = eg; m_streak = 1; end
        else begin m_owner = -1; m_streak = 0; end
      end
    end
  end

  task automatic drv_a(input bit v, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit lk);
    a_req_valid = v; a_req_we = we; a_req_addr = ad; a_req_wdata = d; a_req_lock = lk;
  endtask

  task automatic drv_b(input bit v, input bit we, input logic [AW-1:0] ad, input logic [DW-1:0] d, input bit lk);
    b_req_valid = v; b_req_we = we; b_req_addr = ad; b_req_wdata = d; b_req_lock = lk;
  endtask

  task automatic idle_all();
    drv_a(0, 0, '0, '0, 0);
    drv_b(0, 0, '0, '0, 0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_glog(input string name, input int exp[8], input int n);
    chk({name, "_len"}, glog.size(), n);
    for (int i = 0; i < n && i < glog.size(); i++) chk(name, glog[i], exp[i]);
  endtask

  initial begin
    int exp_c[8];
    int exp_l[8];
    exp_c = '{0, 1, 0, 1, 0, 1, 0, 0};
    exp_l = '{0, 0, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 16; i++) ram_mem[i] = '0;
    idle_all();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single port: write then read back addr 3
    drv_a(1, 1, 4'd3, 8'h5A, 0);
    @(negedge clk); chk("sp_wr_ready", a_req_ready, 1);
    next_cyc();
    drv_a(1, 0, 4'd3, 8'h00, 0);
    @(negedge clk); chk("sp_wr_rsp", {a_rsp_valid, a_rsp_rdata}, {1'b1, 8'h00});
    next_cyc();
    idle_all();
    @(negedge clk); chk("sp_rd_rsp", {a_rsp_valid, a_rsp_rdata}, {1'b1, 8'h5A});
    chk("sp_b_quiet", b_rsp_valid, 0);
    next_cyc();

    // A lone B access makes B the last winner so A takes the next tie
    drv_b(1, 0, 4'd0, 8'h00, 0);
    next_cyc();
    idle_all();
    next_cyc();

    // Contention, no lock
    glog.delete();
    for (int i = 0; i < 6; i++) begin
      drv_a(1, i[0], 4'(8 + i), 8'(8'h10 + i), 0);
      drv_b(1, ~i[0], 4'(8 + i), 8'(8'h20 + i), 0);
      next_cyc();
    end
    idle_all();
    chk_glog("contention_grant", exp_c, 6);
    next_cyc();

    // Locked burst from A against a waiting B
    glog.delete();
    for (int i = 0; i < 8; i++) begin
      drv_a(1, 0, 4'd1, 8'h00, 1);
      drv_b(1, 0, 4'd2, 8'h00, 0);
      next_cyc();
    end
    idle_all();
    chk_glog("burst_grant", exp_l, 8);
    next_cyc();

    // Write from B, read from A on the same address next cycle
    drv_b(1, 1, 4'd7, 8'hC3, 0);
    next_cyc();
    idle_all();
    drv_a(1, 0, 4'd7, 8'h00, 0);
    @(negedge clk); chk("race_b_old", {b_rsp_valid, b_rsp_rdata}, {1'b1, 8'h00});
    next_cyc();
    idle_all();
    @(negedge clk); chk("race_a_new", {a_rsp_valid, a_rsp_rdata}, {1'b1, 8'hC3});
    next_cyc();

    // Reset between acceptance and response
    drv_a(1, 0, 4'd3, 8'h00, 0);
    @(negedge clk); chk("mid_accept", a_req_ready, 1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    idle_all();
    @(negedge clk); chk("mid_drop", a_rsp_valid, 0);
    next_cyc();
    next_cyc();
    rst_n = 1'b1;
    drv_a(1, 0, 4'd3, 8'h00, 0);
    drv_b(1, 0, 4'd4, 8'h00, 0);
    @(negedge clk);
    chk("post_rst_no_rsp", {a_rsp_valid, b_rsp_valid}, 0);
    chk("post_rst_tie", {a_req_ready, b_req_ready}, 2'b10);
    next_cyc();
    idle_all();
    next_cyc();

    // Idle
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_en", ram_en, 0);
      chk("idle_rsp", {a_rsp_valid, b_rsp_valid}, 0);
      chk("idle_lock", dut.u_arb.state_q, UNLOCKED);
      next_cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
